// File: rtl/mips_fetch_sequencer.sv
// Instruction-fetch / PC sequencer for the Harvard MIPS core.
// Drives the instruction address, presents the fetched word to decode,
// sequences branch delay slots, detects misaligned branch targets and
// counts retired instructions. A redirect issued in RUN moves the PC to the
// delay slot first; the target is loaded when the delay slot retires.
module mips_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             stall,
  output logic [31:0]      instr_address,
  input  logic [31:0]      instr_readdata,
  input  logic             instr_waitrequest,
  output logic [31:0]      instr_out,
  output logic             instr_valid,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic [31:0]      link_addr,
  output logic             retire,
  output logic             active,
  output logic             addr_error,
  output logic             delay_branch_error,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DELAY = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pending_target_q, pending_target_d;
  logic             active_q, active_d;
  logic             addr_error_q, addr_error_d;
  logic             delay_branch_error_q, delay_branch_error_d;
  logic [CNT_W-1:0] retired_count_q, retired_count_d;

  logic             advance;
  logic             target_misaligned;
  logic             pending_is_halt;
  logic [31:0]      pc_plus4;

  // Every piece of state moves only on an advance; active_q already encodes
  // HALT so a halted core never advances.
  assign advance           = clk_enable & ~stall & ~instr_waitrequest & active_q;
  assign target_misaligned = |redirect_target[1:0];
  assign pending_is_halt   = (pending_target_q == HALT_ADDR);
  assign pc_plus4          = pc_q + 32'd4;

  // State register; reset restarts from any state, including HALT and DELAY.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next-state logic: transitions happen only on advance cycles.
  always_comb begin
    state_d = state_q;
    if (advance) begin
      case (state_q)
        ST_RUN: begin
          if (redirect_valid) begin
            if (target_misaligned) state_d = ST_HALT;
            else                   state_d = ST_DELAY;
          end
        end
        ST_DELAY: begin
          // A redirect seen here is flagged but does not re-steer.
          if (pending_is_halt) state_d = ST_HALT;
          else                 state_d = ST_RUN;
        end
        default: state_d = ST_HALT;
      endcase
    end
  end

  // Datapath registers: PC, pending target, run flag, sticky errors, counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q                 <= RESET_VECTOR;
      pending_target_q     <= 32'd0;
      active_q             <= 1'b1;
      addr_error_q         <= 1'b0;
      delay_branch_error_q <= 1'b0;
      retired_count_q      <= '0;
    end else begin
      pc_q                 <= pc_d;
      pending_target_q     <= pending_target_d;
      active_q             <= active_d;
      addr_error_q         <= addr_error_d;
      delay_branch_error_q <= delay_branch_error_d;
      retired_count_q      <= retired_count_d;
    end
  end

  // Datapath next values; without an advance everything holds and any
  // redirect presented that cycle is ignored.
  always_comb begin
    pc_d                 = pc_q;
    pending_target_d     = pending_target_q;
    active_d             = active_q;
    addr_error_d         = addr_error_q;
    delay_branch_error_d = delay_branch_error_q;
    retired_count_d      = retired_count_q;
    if (advance) begin
      // The instruction at the PC retires on every advance, including a
      // misaligned branch and the delay slot in front of a halt.
      retired_count_d = retired_count_q + 1'b1;
      case (state_q)
        ST_RUN: begin
          if (redirect_valid) begin
            if (target_misaligned) begin
              // Stop at the offending branch; PC stays on it for debug.
              addr_error_d = 1'b1;
              active_d     = 1'b0;
            end else begin
              pending_target_d = redirect_target;
              pc_d             = pc_plus4;
            end
          end else begin
            pc_d = pc_plus4;
          end
        end
        ST_DELAY: begin
          pc_d = pending_target_q;
          if (pending_is_halt) active_d = 1'b0;
          if (redirect_valid) delay_branch_error_d = 1'b1;
        end
        default: begin
          pc_d = pc_q;
        end
      endcase
    end
  end

  // Outputs toward instruction memory and decode.
  always_comb begin
    instr_address      = pc_q;
    instr_out          = instr_readdata;
    instr_valid        = active_q & ~instr_waitrequest;
    retire             = advance;
    link_addr          = pc_plus4 + 32'd4;
    active             = active_q;
    addr_error         = addr_error_q;
    delay_branch_error = delay_branch_error_q;
    retired_count      = retired_count_q;
  end

endmodule

// File: tb/tb_mips_fetch_sequencer.sv
// Bench for mips_fetch_sequencer: a behavioural model pushes the expected
// outputs of each cycle into a scoreboard as stimulus is driven; each test
// task pops and compares them, plus a few absolute checks from the plan.
module tb_mips_fetch_sequencer;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk, reset, clk_enable, stall, instr_waitrequest, redirect_valid;
  logic [31:0] redirect_target, instr_address, instr_readdata, instr_out, link_addr;
  logic        instr_valid, retire, active, addr_error, delay_branch_error;
  logic [31:0] retired_count;
  logic [31:0] d4_address, d4_readdata, d4_out, d4_link;
  logic        d4_valid, d4_retire, d4_active, d4_ae, d4_dbe;
  logic [3:0]  d4_count;

  assign instr_readdata = ~instr_address;
  assign d4_readdata    = ~d4_address;

  mips_fetch_sequencer dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .stall(stall),
    .instr_address(instr_address), .instr_readdata(instr_readdata),
    .instr_waitrequest(instr_waitrequest), .instr_out(instr_out),
    .instr_valid(instr_valid), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .link_addr(link_addr), .retire(retire),
    .active(active), .addr_error(addr_error),
    .delay_branch_error(delay_branch_error), .retired_count(retired_count)
  );

  mips_fetch_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .stall(stall),
    .instr_address(d4_address), .instr_readdata(d4_readdata),
    .instr_waitrequest(instr_waitrequest), .instr_out(d4_out),
    .instr_valid(d4_valid), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .link_addr(d4_link), .retire(d4_retire),
    .active(d4_active), .addr_error(d4_ae),
    .delay_branch_error(d4_dbe), .retired_count(d4_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc, link, instr;
    logic        valid, retire, active, ae, dbe;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } obs_t;

  typedef struct packed {
    logic        rst, ce, st, wr, rv;
    logic [31:0] rt;
  } stim_t;

  obs_t  sb[$];
  stim_t stim_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;

  // Reference model state (behaviour of the sequencer, not its structure)
  logic [31:0] m_pc, m_pend, m_cnt;
  logic [1:0]  m_st; // 0 run, 1 delay, 2 halt
  logic        m_act, m_ae, m_dbe;

  function automatic obs_t observe();
    observe = '{instr_address, link_addr, instr_out, instr_valid, retire, active,
                addr_error, delay_branch_error, retired_count, d4_count};
  endfunction

  task automatic push_stim(input logic rst, ce, st, wr, rv, input logic [31:0] rt);
    stim_t s;
    s = '{rst, ce, st, wr, rv, rt};
    stim_q.push_back(s);
  endtask

  // Drive one cycle's inputs, record the expected outputs, step the model.
  task automatic cyc(input stim_t s);
    obs_t e;
    logic adv;
    @(negedge clk);
    reset = s.rst; clk_enable = s.ce; stall = s.st; instr_waitrequest = s.wr;
    redirect_valid = s.rv; redirect_target = s.rt;
    adv = s.ce & ~s.st & ~s.wr & m_act;
    e = '{m_pc, m_pc + 32'd8, ~m_pc, m_act & ~s.wr, adv, m_act, m_ae, m_dbe,
          m_cnt, m_cnt[3:0]};
    sb.push_back(e);
    if (s.rst) begin
      m_pc = RV; m_pend = 0; m_cnt = 0; m_st = 0; m_act = 1; m_ae = 0; m_dbe = 0;
    end else if (adv) begin
      m_cnt = m_cnt + 1;
      if (m_st == 0) begin
        if (s.rv && s.rt[1:0] != 0) begin m_ae = 1; m_act = 0; m_st = 2; end
        else if (s.rv) begin m_pend = s.rt; m_pc = m_pc + 4; m_st = 1; end
        else m_pc = m_pc + 4;
      end else if (m_st == 1) begin
        m_pc = m_pend;
        if (m_pend == 32'h0) begin m_st = 2; m_act = 0; end else m_st = 0;
        if (s.rv) m_dbe = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    obs_t o, e;
    stim_t s;
    s = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    cyc(s);
    e = sb.pop_front(); // pre-reset outputs are undefined
    s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    cyc(s);
    o = observe(); e = sb.pop_front(); n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL reset_state: got %h want %h", o, e); end
    n_cmp++;
    if (instr_address !== RV) begin n_fail++; $display("FAIL reset_pc: got %h want %h", instr_address, RV); end
    n_cmp++;
    if ({active, addr_error, delay_branch_error, retired_count} !== {3'b100, 32'd0}) begin
      n_fail++; $display("FAIL reset_flags: got %b/%b/%b/%0d want 1/0/0/0", active, addr_error, delay_branch_error, retired_count);
    end
  endtask

  task automatic test_sequential();
    obs_t o, e; stim_t s; int k = 0;
    push_stim(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) push_stim(0, 1, 0, 0, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); cyc(s);
      o = observe(); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL sequential cyc%0d: got %h want %h", k, o, e); end
      k++;
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({instr_address, retired_count, active} !== {32'hBFC0000C, 32'd3, 1'b1}) begin
      n_fail++; $display("FAIL sequential_end: got pc %h cnt %0d act %b want bfc0000c 3 1", instr_address, retired_count, active);
    end
  endtask

  task automatic test_branch();
    obs_t o, e; stim_t s; int k = 0;
    push_stim(1, 0, 0, 0, 0, 0);
    push_stim(0, 1, 0, 0, 0, 0);
    push_stim(0, 1, 0, 0, 0, 0);
    push_stim(0, 1, 0, 0, 1, 32'hBFC00100);
    push_stim(0, 1, 0, 0, 0, 0);
    push_stim(0, 1, 0, 0, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); cyc(s);
      o = observe(); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL branch cyc%0d: got %h want %h", k, o, e); end
      if (o.pc === 32'hBFC00008) begin
        n_cmp++;
        if (o.link !== 32'hBFC00010) begin n_fail++; $display("FAIL branch_link: got %h want bfc00010", o.link); end
      end
      k++;
    end
    @(posedge clk); #1;
    n_cmp++;
    if (instr_address !== 32'hBFC00104) begin n_fail++; $display("FAIL branch_target: got %h want bfc00104", instr_address); end
  endtask

  task automatic test_halt();
    obs_t o, e; stim_t s; int k = 0;
    push_stim(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) push_stim(0, 1, 0, 0, 0, 0);
    push_stim(0, 1, 0, 0, 1, 32'h0);
    push_stim(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) push_stim(0, 1, 0, 0, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); cyc(s);
      o = observe(); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL halt cyc%0d: got %h want %h", k, o, e); end
      k++;
    end
    n_cmp++;
    if ({instr_address, active, retire, instr_valid, retired_count} !== {32'h0, 3'b000, 32'd6}) begin
      n_fail++; $display("FAIL halt_end: got pc %h act %b ret %b val %b cnt %0d want 0 0 0 0 6", instr_address, active, retire, instr_valid, retired_count);
    end
  endtask

  task automatic test_hold();
    obs_t o, e; stim_t s; int k = 0;
    push_stim(1, 0, 0, 0, 0, 0);
    push_stim(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) push_stim(0, 1, 0, 1, 1, 32'hBFC00200);
    for (int i = 0; i < 2; i++) push_stim(0, 1, 1, 0, 1, 32'hBFC00200);
    for (int i = 0; i < 2; i++) push_stim(0, 0, 0, 0, 1, 32'hBFC00200);
    push_stim(0, 1, 0, 0, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); cyc(s);
      o = observe(); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL hold cyc%0d: got %h want %h", k, o, e); end
      k++;
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({instr_address, retired_count} !== {32'hBFC00008, 32'd2}) begin
      n_fail++; $display("FAIL hold_resume: got pc %h cnt %0d want bfc00008 2", instr_address, retired_count);
    end
  endtask

  task automatic test_misaligned();
    obs_t o, e; stim_t s; int k = 0;
    push_stim(1, 0, 0, 0, 0, 0);
    push_stim(0, 1, 0, 0, 0, 0);
    push_stim(0, 1, 0, 0, 0, 0);
    push_stim(0, 1, 0, 0, 1, 32'hBFC00102);
    for (int i = 0; i < 3; i++) push_stim(0, 1, 0, 0, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); cyc(s);
      o = observe(); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL misaligned cyc%0d: got %h want %h", k, o, e); end
      k++;
    end
    n_cmp++;
    if ({instr_address, addr_error, active} !== {32'hBFC00008, 2'b10}) begin
      n_fail++; $display("FAIL misaligned_end: got pc %h ae %b act %b want bfc00008 1 0", instr_address, addr_error, active);
    end
  endtask

  task automatic test_delay_redirect();
    obs_t o, e; stim_t s; int k = 0;
    push_stim(1, 0, 0, 0, 0, 0);
    push_stim(0, 1, 0, 0, 1, 32'hBFC00100);
    push_stim(0, 1, 0, 0, 1, 32'hBFC00200);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); cyc(s);
      o = observe(); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL delay_redirect cyc%0d: got %h want %h", k, o, e); end
      k++;
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({instr_address, delay_branch_error, active} !== {32'hBFC00100, 2'b11}) begin
      n_fail++; $display("FAIL delay_redirect_end: got pc %h dbe %b act %b want bfc00100 1 1", instr_address, delay_branch_error, active);
    end
  endtask

  task automatic test_reset_in_delay();
    obs_t o, e; stim_t s; int k = 0;
    push_stim(1, 0, 0, 0, 0, 0);
    push_stim(0, 1, 0, 0, 1, 32'hBFC00100);
    push_stim(0, 1, 0, 0, 1, 32'hBFC00200);
    push_stim(0, 1, 0, 0, 1, 32'hBFC00300);
    push_stim(1, 1, 0, 0, 1, 32'hBFC00400);
    push_stim(0, 0, 0, 0, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); cyc(s);
      o = observe(); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL reset_in_delay cyc%0d: got %h want %h", k, o, e); end
      k++;
    end
    n_cmp++;
    if ({instr_address, active, addr_error, delay_branch_error, retired_count} !== {RV, 3'b100, 32'd0}) begin
      n_fail++; $display("FAIL reset_in_delay_end: got pc %h act %b ae %b dbe %b cnt %0d want bfc00000 1 0 0 0", instr_address, active, addr_error, delay_branch_error, retired_count);
    end
  endtask

  task automatic test_pc_wrap();
    obs_t o, e; stim_t s; int k = 0;
    push_stim(1, 0, 0, 0, 0, 0);
    push_stim(0, 1, 0, 0, 1, 32'hFFFFFFF8);
    for (int i = 0; i < 3; i++) push_stim(0, 1, 0, 0, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); cyc(s);
      o = observe(); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL pc_wrap cyc%0d: got %h want %h", k, o, e); end
      k++;
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({instr_address, active, addr_error} !== {32'h0, 2'b10}) begin
      n_fail++; $display("FAIL pc_wrap_end: got pc %h act %b ae %b want 0 1 0", instr_address, active, addr_error);
    end
  endtask

  task automatic test_counter_wrap();
    obs_t o, e; stim_t s; int k = 0;
    push_stim(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) push_stim(0, 1, 0, 0, 0, 0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); cyc(s);
      o = observe(); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL counter_wrap cyc%0d: got %h want %h", k, o, e); end
      k++;
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({d4_count, retired_count} !== {4'd1, 32'd17}) begin
      n_fail++; $display("FAIL counter_wrap_end: got cnt4 %0d cnt %0d want 1 17", d4_count, retired_count);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o, e; stim_t s;
    logic [31:0] rt;
    push_stim(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      rt = ($urandom & 32'hFFFFFFFC) | 32'h100;
      if ($urandom_range(0, 19) == 0) rt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 29) == 0) rt = 32'h0;
      push_stim($urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 3) == 0, rt);
    end
    for (int k = 0; stim_q.size() > 0; k++) begin
      s = stim_q.pop_front(); cyc(s);
      o = observe(); e = sb.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL back_to_back cyc%0d: got %h want %h", k, o, e); end
    end
  endtask

  initial begin
    reset = 1'b0; clk_enable = 1'b0; stall = 1'b0; instr_waitrequest = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    m_pc = 0; m_pend = 0; m_cnt = 0; m_st = 0; m_act = 0; m_ae = 0; m_dbe = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_halt();
    test_hold();
    test_misaligned();
    test_delay_redirect();
    test_reset_in_delay();
    test_pc_wrap();
    test_counter_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_fetch_sequencer.md
Name: mips_fetch_sequencer

Overview:
- Parametrised instruction-fetch and PC sequencer for the next-generation Harvard MIPS core.
- Generalises the current fixed PC/active/halt handling. Adds:
  - a configurable reset vector and halt address;
  - real clk_enable gating;
  - an instruction-memory waitrequest handshake;
  - branch-delay-slot sequencing;
  - misaligned-target error detection;
  - a retired-instruction counter.
- Sits between the instruction memory port and the decode/control path.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDR, 32'h00000000, redirect target that stops the CPU after its delay slot.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- clk_enable  in  1  global advance enable; when low, all state holds.
- stall  in  1  back-end stall (e.g. data memory busy); when high, holds the PC.
- instr_address  out  32  current PC, driven to instruction memory.
- instr_readdata  in  32  instruction word at instr_address (combinational).
- instr_waitrequest  in  1  instruction memory not ready; when high, holds the PC.
- instr_out  out  32  instruction presented to decode (equals instr_readdata).
- instr_valid  out  1  instr_out is valid this cycle.
- redirect_valid  in  1  decode: the instruction at the current PC is a taken branch or jump.
- redirect_target  in  32  target of that branch or jump.
- link_addr  out  32  PC+8, the return address for JAL/JALR/BxxAL.
- retire  out  1  pulse: the instruction at the PC completes this cycle.
- active  out  1  CPU running.
- addr_error  out  1  sticky: a misaligned redirect target was seen.
- delay_branch_error  out  1  sticky: a redirect was seen in a delay slot.
- retired_count  out  CNT_W  number of retired instructions, wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, overrides every other input on the same edge):
  - pc=RESET_VECTOR, state=RUN, active=1;
  - addr_error=0, delay_branch_error=0, retired_count=0;
  - pending_target=0.
- Reset asserted mid-operation, in any state (including HALT or DELAY), fully restarts the block.
- advance = clk_enable & ~stall & ~instr_waitrequest & active.
- Combinational outputs:
  - instr_valid = active & ~instr_waitrequest;
  - retire = advance;
  - instr_out = instr_readdata;
  - link_addr = pc+4+4, with 32-bit wrap.
- States:
  - RUN, normal sequencing;
  - DELAY, executing a delay slot with a target pending;
  - HALT, stopped.
- RUN, on an advance cycle:
  - If redirect_valid and redirect_target[1:0]==0: pending_target<=redirect_target, pc<=pc+4, state<=DELAY.
  - If redirect_valid and redirect_target[1:0]!=0: addr_error<=1, active<=0, state<=HALT. The PC holds.
  - If redirect_valid is low: pc<=pc+4.
- DELAY, on an advance cycle:
  - pc<=pending_target.
  - If pending_target==HALT_ADDR: state<=HALT, active<=0. The delay-slot instruction still retires.
  - Otherwise state<=RUN.
  - If redirect_valid is high, the redirect is ignored and delay_branch_error<=1 (sticky).
- HALT:
  - PC frozen; active=0; instr_valid=0; retire=0.
  - Left only by reset.
- No advance (clk_enable low, stall high, or waitrequest high): pc, state, pending_target and counter all hold. redirect_valid is ignored in that cycle.
- Decode must hold redirect_valid and redirect_target stable until the advance cycle.
- retired_count increments by 1 on each advance cycle and wraps from all-ones to 0.
- PC arithmetic is 32-bit; 32'hFFFFFFFC+4 wraps to 0 without error.
- Latency:
  - A redirect takes effect two retirements later: branch, then delay slot, then target.
  - A halt redirect drops active on the edge that retires the delay slot.

Test Plan:
- Reset, then clk_enable=1 with no stalls for 3 cycles:
  - instr_address = BFC00000, BFC00004, BFC00008;
  - retired_count=3; active=1.
- Redirect to 0xBFC00100 at PC 0xBFC00008:
  - next PC 0xBFC0000C (delay slot), then 0xBFC00100;
  - state returns to RUN; link_addr at the branch = 0xBFC00010.
- Redirect to 0x00000000 at PC 0xBFC00010:
  - delay slot 0xBFC00014 retires;
  - next edge active=0, PC=0; retire stays 0 for 10 further cycles.
- Hold instr_waitrequest=1 for 4 cycles, then stall=1 for 2 cycles, then clk_enable=0 for 2 cycles:
  - PC and retired_count unchanged throughout;
  - instr_valid=0 only during waitrequest;
  - resumes at PC+4 afterwards.
- Redirect target 0xBFC00102:
  - addr_error=1, active=0, PC held at the branch address.
- Redirect again inside a delay slot:
  - delay_branch_error=1; the original target is taken.
- Reset asserted while in DELAY:
  - PC=BFC00000, state RUN, both error flags cleared.
- With CNT_W=4, 17 retirements:
  - retired_count=1.
